// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions used by the display encoder and by ssd_decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ssd_pkg;

    // Segment patterns, bit order g..a (bit6 = g, bit0 = a).
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal codes reported in the packed BCD result.
    localparam logic [3:0] DIG_DASH  = 4'hF;
    localparam logic [3:0] DIG_BLANK = 4'hE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } ssd_state_t;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational seven-segment pattern to digit lookup; unknown patterns flag err.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: seg (g..a pattern) -> digit (BCD / DIG_DASH / DIG_BLANK), err (illegal pattern).
module ssd_pattern_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       err
);

    always_comb begin
        digit = DIG_BLANK;
        err   = 1'b0;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_DASH:  digit = DIG_DASH;
            SEG_BLANK: digit = DIG_BLANK;
            default: begin
                digit = DIG_BLANK;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ssd_decoder.sv
// Sniffs a multiplexed 7-segment bus and recovers the shown digits as packed BCD.
// Latency: capture STABLE_CYCLES-1 edges after the first sample (+2 with SSD_DECODER_SYNC_EN).
// Backpressure: none; passive monitor, frame_valid is a one-cycle pulse.
// Ports: CLK/RST_N (async active-low), seg_in (a..g), an_in (one-hot digit enable),
//        clear (sync flush of partial frame), value (digit i at [4i+3:4i]),
//        digit_err (per-digit illegal flag), frame_valid / frame_err (frame result).
// Optional: define SSD_DECODER_SYNC_EN to add a 2-flop synchronizer on seg_in/an_in.
module ssd_decoder
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
)(
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Polarity-corrected pins.
    logic [6:0]            seg_c;
    logic [NUM_DIGITS-1:0] an_c;
    assign seg_c = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
    assign an_c  = (AN_ACTIVE_LOW  != 0) ? ~an_in  : an_in;

    // Sample arriving at the input register on the next edge.
    logic [6:0]            seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

`ifdef SSD_DECODER_SYNC_EN
    logic [6:0]            seg_s1, seg_s2;
    logic [NUM_DIGITS-1:0] an_s1, an_s2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            an_s1  <= '0;
            an_s2  <= '0;
        end else begin
            seg_s1 <= seg_c;
            seg_s2 <= seg_s1;
            an_s1  <= an_c;
            an_s2  <= an_s1;
        end
    end

    assign seg_nxt = seg_s2;
    assign an_nxt  = an_s2;
`else
    assign seg_nxt = seg_c;
    assign an_nxt  = an_c;
`endif

    // Input sample register: decode always works from this copy.
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            seg_q <= seg_nxt;
            an_q  <= an_nxt;
        end
    end

    // The FSM state describes the registered sample. Each edge it judges the
    // sample being loaded against the one already held, so the counter equals
    // the number of identical samples registered once this edge completes.
    logic nxt_onehot;
    logic nxt_same;
    assign nxt_onehot = (an_nxt != '0) && ((an_nxt & (an_nxt - NUM_DIGITS'(1))) == '0);
    assign nxt_same   = (an_nxt == an_q) && (seg_nxt == seg_q);

    ssd_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          cap;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        case (state_q)
            IDLE: begin
                if (nxt_onehot) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!nxt_onehot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!nxt_same) begin
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = cnt_inc;
                    // Registered sample equals the incoming one here, so
                    // decoding seg_q captures exactly the stable pattern.
                    if (cnt_inc == CNT_MAX) begin
                        cap     = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!nxt_onehot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!nxt_same) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture datapath.
    logic [3:0]            dec_digit;
    logic                  dec_err;
    logic [NUM_DIGITS-1:0] mask_q;
    logic [NUM_DIGITS-1:0] mask_upd;
    logic [NUM_DIGITS-1:0] err_upd;
    logic                  frame_done;

    ssd_pattern_decode u_decode (
        .seg   (seg_q),
        .digit (dec_digit),
        .err   (dec_err)
    );

    assign mask_upd   = mask_q | an_q;
    assign err_upd    = (digit_err & ~an_q) | (an_q & {NUM_DIGITS{dec_err}});
    assign frame_done = cap && !clear && (mask_upd == {NUM_DIGITS{1'b1}});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value       <= '0;
            digit_err   <= '0;
            mask_q      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            frame_err   <= frame_done && (|err_upd);
            if (clear) begin
                mask_q    <= '0;
                digit_err <= '0;
            end else if (cap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_q[i]) begin
                        value[4*i +: 4] <= dec_digit;
                    end
                end
                // Completed frame: flags leave through frame_err, next frame starts clean.
                if (frame_done) begin
                    mask_q    <= '0;
                    digit_err <= '0;
                end else begin
                    mask_q    <= mask_upd;
                    digit_err <= err_upd;
                end
            end
        end
    end

endmodule

// File: doc/ssd_decoder.md
Name: ssd_decoder

Overview:
- Reverse direction of the team's BCD-to-7-segment encoder: it monitors a multiplexed seven-segment display bus (segment lines plus one-hot digit enables) and recovers the displayed digits as packed BCD.
- Used as a loopback checker and display-sniffer alongside the display drivers.
- A digit is accepted only after its bus pattern has been stable for a set number of cycles.
- A frame result is emitted once every digit position has been captured.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required before a capture (2..255).
- SEG_ACTIVE_LOW, 0: 1 means seg_in is inverted before decoding.
- AN_ACTIVE_LOW, 0: 1 means an_in is inverted before the one-hot check.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- seg_in  input  7  segment lines, bit0=a … bit6=g.
- an_in  input  NUM_DIGITS  digit enables, one-hot when valid.
- clear  input  1  synchronous; empties the capture mask and digit_err.
- value  output  4*NUM_DIGITS  packed digits; digit i occupies [4i+3:4i].
- digit_err  output  NUM_DIGITS  per-digit illegal-pattern flag for the current frame.
- frame_valid  output  1  one-cycle pulse when all digits have been captured.
- frame_err  output  1  OR of digit_err at frame completion; valid with frame_valid.

Behaviour:
- Reset (RST_N low, asynchronous): value=0, digit_err=0, frame_valid=0, frame_err=0, capture mask=0, stability counter=0, FSM=IDLE, input sample registers=0.
- Input stage: seg_in and an_in are registered every cycle (after polarity correction). Decoding and stability checks use only the registered sample.
- Pattern decode (shared lookup, seg = g..a):
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4, 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9.
  - 1000000 (dash)→4'hF, legal.
  - 0000000 (blank)→4'hE, legal.
  - Any other pattern→4'hE with the error flag set.
- FSM states:
  - IDLE: registered an is not exactly one-hot (zero or multi-hot). Counter held at 0.
    - Next-cycle valid one-hot sample → SETTLE, counter=1.
  - SETTLE: each sample whose {an,seg} equals the previous sample increments the counter.
    - A differing sample reloads counter=1 and stays in SETTLE; a non-one-hot sample → IDLE.
    - When the counter reaches STABLE_CYCLES: capture on that edge, then → HOLD.
  - HOLD: a dwell is captured only once. A change of {an,seg} → SETTLE (counter=1), or → IDLE if not one-hot.
- Capture:
  - Digit index idx = position of the set an bit.
  - value[4idx+:4] ← decoded digit; digit_err[idx] ← error flag; mask[idx] ← 1.
  - Recapturing an already-set position before the frame completes overwrites value and digit_err; the mask is unchanged.
- Latency: a pattern stable on the pins from before edge 0 is registered at edge 0 and captured at edge STABLE_CYCLES-1 (edge 3 by default).
- Frame completion:
  - On the edge where a capture makes the mask all-ones: frame_valid=1 for exactly one cycle.
  - frame_err = OR of the updated digit_err.
  - On that same edge the mask clears and digit_err clears (the flags are reported through frame_err).
  - value holds until overwritten by later captures.
- clear: takes priority over a simultaneous capture. mask=0, digit_err=0, no frame_valid; value is untouched; the FSM is unaffected.
- NUM_DIGITS=1: every capture completes a frame.
- Counter width: clog2(STABLE_CYCLES+1). It saturates and never wraps.
- Reset asserted mid-dwell or mid-frame: all state returns to reset values immediately; a partial frame is discarded.

Optional Feature:
- Macro: SSD_DECODER_SYNC_EN.
- Defined: a 2-flop synchronizer is placed on seg_in and an_in ahead of the input register (reset to 0 by RST_N). Every capture/frame timing shifts 2 cycles later; the bus is treated as asynchronous to CLK.
- Undefined: no synchronizer; seg_in and an_in are assumed synchronous to CLK.

Decomposition:
- Package ssd_pkg holds:
  - The ten digit segment constants plus SEG_DASH (7'b1000000) and SEG_BLANK (7'b0000000).
  - Code constants DIG_DASH=4'hF and DIG_BLANK=4'hE.
  - FSM state enum {IDLE, SETTLE, HOLD}.
  - Shared by the encoder and this block.
- Sub-module ssd_pattern_decode: combinational seg[6:0]→{err, digit[3:0]} lookup, reusable by other checkers.

Test Plan:
1. Reset then hold an=0001, seg=1011011 for 4 cycles → value[3:0]=2 captured at edge 3; no frame_valid yet.
2. Scan digits 0..3 with patterns for 4,0,9,dash, each dwelling 6 cycles → one frame_valid pulse, value=16'hF904, frame_err=0; exactly one capture per dwell.
3. Pattern toggles every 2 cycles (glitching, STABLE_CYCLES=4) → no capture, value unchanged, FSM never leaves SETTLE.
4. Digit 2 shows illegal 0101010 within a full scan → digit 2 value=E, frame_err=1 with frame_valid; digit_err=0 afterward.
5. an=0011 (multi-hot) for 10 cycles → FSM stays IDLE, no capture. Then clear pulsed on the same edge as the final capture of a frame → no frame_valid, mask=0.
6. RST_N dropped asynchronously mid-frame after 2 captures → all outputs 0 immediately. After release, a full 4-digit scan is needed before frame_valid.
